crc8_lfsr: RTL and testbench
============================

Name: crc8_lfsr

Overview:
- Serial 8-bit CRC generator built on a Galois-style LFSR.
- While ACTIVE is high, it absorbs one message bit per clock.
- When ACTIVE drops, it shifts the 8-bit CRC out serially, LSB first, with Valid asserted for exactly 8 cycles.
- Sits on a serial link between the frame source and the transmitter.

Parameters:
- WIDTH, 8, LFSR and CRC length in bits.
- SEED, 8'hD8, LFSR value loaded on reset and at the start of every message.
- TAPS, 8'b0100_0100, feedback tap mask. A set bit i (i<7) means LFSR[i] <= LFSR[i+1] ^ feedback.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- ACTIVE  input  1  high while message bits are presented on DATA
- DATA  input  1  serial message bit, LSB of each byte first, sampled on CLK rise when ACTIVE=1
- CRC  output  1  serial CRC bit, registered, LSB first
- Valid  output  1  high while CRC carries a valid bit, registered

Behaviour:
- Reset (RST=1 at a CLK rise) has priority over everything, including mid-message and mid-output:
  - LFSR=SEED, bit counter=0, CRC=0, Valid=0, state=IDLE.
- Feedback is fb = DATA ^ LFSR[0].
- On each absorb cycle:
  - LFSR[WIDTH-1] <= fb.
  - For i<WIDTH-1: LFSR[i] <= LFSR[i+1] ^ (TAPS[i] & fb).
  - With defaults, bit 6 and bit 2 receive XOR with fb; all other bits shift right.
- State machine (3 states):
  - IDLE: CRC=0, Valid=0, LFSR holds SEED. ACTIVE=1 absorbs DATA this cycle and goes to CALC.
  - CALC: ACTIVE=1 absorbs DATA. ACTIVE=0 drives CRC<=LFSR[0], shifts the LFSR right (MSB fill 0), sets Valid<=1, counter<=1, and goes to OUT.
  - OUT, counter<8, ACTIVE=0: CRC<=LFSR[0], shift right, Valid=1, counter+1.
  - OUT, counter==8, ACTIVE=0: Valid<=0, CRC<=0, LFSR<=SEED, counter<=0, go to IDLE.
  - OUT, ACTIVE=1 at any counter value: abort the output (Valid<=0, CRC<=0), restart absorption from SEED using the current DATA bit, go to CALC.
- Timing of the output phase:
  - First CRC bit appears on the first CLK rise that samples ACTIVE=0 after CALC.
  - Valid is high for exactly 8 consecutive cycles, carrying LFSR[0..7] in order.
- ACTIVE=0 in IDLE: no change. Valid never asserts without a preceding absorbed bit.
- Messages may be any number of bits ≥1; the bench uses 8-bit messages.
- Back-to-back frames need no reset, because the LFSR reloads SEED after output completes.

Optional Feature:
- Macro CRC_DONE_PULSE_EN.
- Defined: adds output port Done (1 bit, reset 0). Done pulses high for one cycle on the cycle following the 8th Valid bit, i.e. the OUT->IDLE transition cycle. An aborted output produces no Done.
- Undefined: no Done port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset, then message 8'h00 (DATA=0 for 8 cycles with ACTIVE=1), then ACTIVE=0 -> next 8 cycles CRC = 0,0,1,0,1,0,0,0 (8'h14, LSB first), Valid=1 for exactly those 8 cycles, then Valid=0 and CRC=0.
- Ten 8-bit messages from a vector file, each followed by 8 sampled output bits -> each reassembled byte equals the golden CRC from the software model (SEED 8'hD8, TAPS 8'h44). Run once with RST between cases and once back-to-back without RST; both runs give identical results.
- RST=1 asserted in the middle of CALC and again in the middle of OUT -> next cycle Valid=0, CRC=0, and the following message 8'h00 still yields 8'h14.
- ACTIVE re-asserted after 3 output bits -> Valid drops the next cycle, and the new 8-bit message yields its standalone golden CRC.
- ACTIVE=0 held for 20 cycles after reset -> Valid and CRC stay 0 throughout.
- With CRC_DONE_PULSE_EN defined -> Done=1 for exactly one cycle right after the 8th Valid cycle; Done stays 0 in the abort scenario.

Source files
------------

// File: rtl/crc8_lfsr.sv
// Serial CRC-8 generator: Galois LFSR absorbs one message bit per clock, then shifts the CRC out LSB first.
// Optional macro CRC_DONE_PULSE_EN adds a one-cycle Done pulse when an output phase completes.
module crc8_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'hD8,
  parameter logic [WIDTH-1:0] TAPS  = 8'b0100_0100
) (
  input  logic CLK,
  input  logic RST,
  input  logic ACTIVE,
  input  logic DATA,
  output logic CRC,
  output logic Valid
`ifdef CRC_DONE_PULSE_EN
  , output logic Done
`endif
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [CW-1:0]    cnt;

  // One absorb step: feedback enters the MSB and is folded into every tapped bit.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s, input logic d);
    logic [WIDTH-1:0] n;
    logic             fb;
    fb         = d ^ s[0];
    n[WIDTH-1] = fb;
    for (int i = 0; i < WIDTH - 1; i++) n[i] = s[i+1] ^ (TAPS[i] & fb);
    return n;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      lfsr  <= SEED;
      cnt   <= '0;
      CRC   <= 1'b0;
      Valid <= 1'b0;
`ifdef CRC_DONE_PULSE_EN
      Done  <= 1'b0;
`endif
    end else begin
`ifdef CRC_DONE_PULSE_EN
      Done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ACTIVE) begin
            lfsr  <= step(lfsr, DATA);
            state <= CALC;
          end
        end
        CALC: begin
          if (ACTIVE) begin
            lfsr <= step(lfsr, DATA);
          end else begin
            CRC   <= lfsr[0];
            lfsr  <= {1'b0, lfsr[WIDTH-1:1]};
            Valid <= 1'b1;
            cnt   <= CW'(1);
            state <= OUT;
          end
        end
        OUT: begin
          if (ACTIVE) begin
            // New frame interrupts the output: restart from the seed with this bit.
            CRC   <= 1'b0;
            Valid <= 1'b0;
            lfsr  <= step(SEED, DATA);
            cnt   <= '0;
            state <= CALC;
          end else if (cnt == LAST) begin
            CRC   <= 1'b0;
            Valid <= 1'b0;
            lfsr  <= SEED;
            cnt   <= '0;
            state <= IDLE;
`ifdef CRC_DONE_PULSE_EN
            Done  <= 1'b1;
`endif
          end else begin
            CRC  <= lfsr[0];
            lfsr <= {1'b0, lfsr[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_lfsr.sv
// Scoreboard bench for crc8_lfsr: stimulus queues expected (bit, cycle) pairs, a negedge monitor checks every cycle.
module tb_crc8_lfsr;

  localparam logic [7:0] SEED = 8'hD8;
  localparam logic [7:0] TAPS = 8'h44;

  logic clk = 1'b0;
  logic rst, active, data;
  logic crc, valid;
`ifdef CRC_DONE_PULSE_EN
  logic done;
`endif

  always #5 clk = ~clk;

  crc8_lfsr dut (
    .CLK(clk), .RST(rst), .ACTIVE(active), .DATA(data),
    .CRC(crc), .Valid(valid)
`ifdef CRC_DONE_PULSE_EN
    , .Done(done)
`endif
  );

  typedef struct { logic b; int cyc; } exp_t;
  exp_t q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, req);
    end
  endtask

  // Reference CRC: bitwise polynomial division, message LSB first, feedback mask = MSB plus taps.
  function automatic logic [7:0] crc_ref(input logic [7:0] m);
    int c, fb;
    c = SEED;
    for (int i = 0; i < 8; i++) begin
      fb = ((m >> i) & 1) ^ (c & 1);
      c  = (c >> 1) ^ (fb != 0 ? (32'h80 | TAPS) : 0);
    end
    return c[7:0];
  endfunction

  // Monitor: an output bit is due only when the scoreboard holds one for this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check("valid_high", valid, 1'b1);
        check("crc_bit", crc, e.b);
      end else begin
        check("valid_low", valid, 1'b0);
        check("crc_zero", crc, 1'b0);
      end
`ifdef CRC_DONE_PULSE_EN
      begin
        logic dexp;
        dexp = (done_q.size() > 0 && done_q[0] == cyc);
        if (dexp) void'(done_q.pop_front());
        check("done", done, dexp);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed 8 message bits, then let n_out CRC bits emerge; n_out==8 completes back to IDLE.
  task automatic send_msg(input logic [7:0] m, input logic [7:0] expv, input int n_out);
    for (int i = 0; i < 8; i++) begin
      active = 1'b1;
      data   = m[i];
      tick();
    end
    active = 1'b0;
    data   = 1'b0;
    for (int i = 0; i < n_out; i++) begin
      q.push_back('{b: expv[i], cyc: cyc + 1});
      tick();
    end
    if (n_out == 8) begin
      done_q.push_back(cyc + 1);
      tick();
    end
  endtask

  logic [7:0] msgs [10];
  logic [7:0] m1, m2;

  initial begin
    rst = 1'b1; active = 1'b0; data = 1'b0;
    tick(); tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Idle with ACTIVE low: random DATA must never wake the output.
    for (int i = 0; i < 20; i++) begin
      data = 1'($urandom_range(0, 1));
      tick();
    end
    data = 1'b0;

    // Known answer: all-zero message gives 8'h14.
    send_msg(8'h00, 8'h14, 8);

    for (int k = 0; k < 10; k++) msgs[k] = 8'($urandom);
    msgs[0] = 8'hFF;

    // Run with a reset between frames.
    for (int k = 0; k < 10; k++) begin
      rst = 1'b1; tick(); rst = 1'b0;
      send_msg(msgs[k], crc_ref(msgs[k]), 8);
    end
    // Same frames back to back, no reset.
    for (int k = 0; k < 10; k++) send_msg(msgs[k], crc_ref(msgs[k]), 8);

    // Reset in the middle of absorption.
    for (int i = 0; i < 4; i++) begin
      active = 1'b1; data = 1'($urandom_range(0, 1)); tick();
    end
    rst = 1'b1; active = 1'b0; tick(); rst = 1'b0;
    tick();
    send_msg(8'h00, 8'h14, 8);

    // Reset in the middle of the output phase.
    m1 = 8'($urandom);
    send_msg(m1, crc_ref(m1), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    send_msg(8'h00, 8'h14, 8);

    // Abort after 3 output bits by re-asserting ACTIVE; no Done for the aborted frame.
    m1 = 8'($urandom);
    m2 = 8'($urandom);
    send_msg(m1, crc_ref(m1), 3);
    send_msg(m2, crc_ref(m2), 8);

    for (int i = 0; i < 4; i++) tick();
    mon_en = 1'b0;

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL crc_bits_outstanding got=%0d expected=0", q.size());
    end
`ifdef CRC_DONE_PULSE_EN
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_outstanding got=%0d expected=0", done_q.size());
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
